adder_16bit_serial: RTL and testbench



---
 rtl/adder_pkg.sv | 12 +
 rtl/adder_4bit.sv | 15 +
 rtl/adder_16bit_serial.sv | 129 ++++++++++++
 tb/tb_adder_16bit_serial.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encodings and slice width.
package adder_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_4bit.sv
// 4-bit adder slice with carry in and carry out.
module adder_4bit (
    output logic [3:0] S,
    output logic       c_out,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       c_in
);

    // Full 5-bit sum so that the carry out of bit 3 is kept.
    always_comb begin
        {c_out, S} = {1'b0, A} + {1'b0, B} + {4'b0000, c_in};
    end

endmodule

// File: rtl/adder_16bit_serial.sv
// Multi-cycle adder: one 4-bit slice is reused for every nibble, LSB nibble first.
// The operand and carry registers feed the slice, and each sum nibble is written into S.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | in_ready high; waiting for an operand set
// ST_RUN  | one nibble per cycle through the slice; carry is registered
// ST_DONE | out_valid high; S/c_out/ovf held until out_ready
module adder_16bit_serial
    import adder_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int NIB   = WIDTH / NIB_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             c_out,
    output logic             ovf
);

    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_reg, b_reg, s_reg;
    logic               carry_reg, ovf_reg;
    logic [IDX_W-1:0]   idx;
    logic               accept, step, last;
    logic [NIB_W-1:0]   nib_a, nib_b, nib_s;
    logic               nib_c;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign last      = (idx == IDX_W'(NIB - 1));
    assign S         = s_reg;
    assign c_out     = carry_reg;
    assign ovf       = ovf_reg;

    // Select the operand nibbles addressed by idx.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int k = 0; k < NIB; k++) begin
            if (idx == IDX_W'(k)) begin
                nib_a = a_reg[k*NIB_W +: NIB_W];
                nib_b = b_reg[k*NIB_W +: NIB_W];
            end
        end
    end

    adder_4bit u_slice (
        .S     (nib_s),
        .c_out (nib_c),
        .A     (nib_a),
        .B     (nib_b),
        .c_in  (carry_reg)
    );

    // Next-state decode plus the accept/step strobes for the datapath.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (last) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Operand, carry and index registers; ovf is captured with the final nibble.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            a_reg     <= A;
            b_reg     <= B;
            carry_reg <= c_in;
            idx       <= '0;
        end else if (step) begin
            carry_reg <= nib_c;
            idx       <= idx + 1'b1;
            if (last) begin
                ovf_reg <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                           (nib_s[NIB_W-1] != a_reg[WIDTH-1]);
            end
        end
    end

    // Write the slice sum into the nibble of S addressed by idx.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_reg <= '0;
        end else if (step) begin
            for (int k = 0; k < NIB; k++) begin
                if (idx == IDX_W'(k)) s_reg[k*NIB_W +: NIB_W] <= nib_s;
            end
        end
    end

endmodule

// File: tb/tb_adder_16bit_serial.sv
// Directed bench for adder_16bit_serial: handshake timing, carries, overflow,
// backpressure, mid-operation reset and input sampling.
module tb_adder_16bit_serial;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        c_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] S;
    logic        c_out;
    logic        ovf;

    int n_checks = 0;
    int n_pass   = 0;

    adder_16bit_serial #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Present an operand set in IDLE; returns in the first RUN cycle.
    task automatic accept_op(input logic [15:0] a, input logic [15:0] b, input logic ci);
        @(negedge clk);
        A        = a;
        B        = b;
        c_in     = ci;
        in_valid = 1'b1;
        chk1("in_ready_before_accept", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk1("in_ready_in_run", in_ready, 1'b0);
    endtask

    // From the first RUN cycle: out_valid must stay low for the RUN cycles and rise
    // exactly NIB cycles after accept. Optionally scramble A/B while running.
    task automatic expect_result(input string tag, input logic [15:0] s_exp,
                                 input logic c_exp, input logic o_exp, input bit scramble);
        chk1({tag, "_run0_out_valid"}, out_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (scramble) begin
                A = 16'($urandom);
                B = 16'($urandom);
                c_in = 1'($urandom);
            end
            @(negedge clk);
            chk1({tag, "_run_out_valid"}, out_valid, 1'b0);
        end
        @(negedge clk);
        chk1({tag, "_out_valid"}, out_valid, 1'b1);
        chk1({tag, "_in_ready_done"}, in_ready, 1'b0);
        chk16({tag, "_S"}, S, s_exp);
        chk1({tag, "_c_out"}, c_out, c_exp);
        chk1({tag, "_ovf"}, ovf, o_exp);
    endtask

    // Expect the result to have transferred at the previous edge.
    task automatic expect_idle(input string tag);
        @(negedge clk);
        chk1({tag, "_idle_in_ready"}, in_ready, 1'b1);
        chk1({tag, "_idle_out_valid"}, out_valid, 1'b0);
    endtask

    initial begin
        int stray;
        rst       = 1'b1;
        in_valid  = 1'b1;
        A         = 16'hDEAD;
        B         = 16'hBEEF;
        c_in      = 1'b1;
        out_ready = 1'b1;

        // Reset with a handshake pending: reset wins.
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk16("rst_S", S, 16'h0000);
        chk1("rst_c_out", c_out, 1'b0);
        chk1("rst_ovf", ovf, 1'b0);
        rst = 1'b0;

        // Carry-free add.
        accept_op(16'h1234, 16'h4321, 1'b0);
        expect_result("nocarry", 16'h5555, 1'b0, 1'b0, 1'b0);
        expect_idle("nocarry");

        // Full ripple through all nibbles.
        accept_op(16'hFFFF, 16'h0001, 1'b0);
        expect_result("ripple", 16'h0000, 1'b1, 1'b0, 1'b0);
        expect_idle("ripple");

        // Ripple driven by c_in.
        accept_op(16'h0FFF, 16'h0000, 1'b1);
        expect_result("cin_ripple", 16'h1000, 1'b0, 1'b0, 1'b0);
        expect_idle("cin_ripple");

        // Positive overflow.
        accept_op(16'h7FFF, 16'h0001, 1'b0);
        expect_result("pos_ovf", 16'h8000, 1'b0, 1'b1, 1'b0);
        expect_idle("pos_ovf");

        // Negative overflow with carry out.
        accept_op(16'h8000, 16'h8000, 1'b0);
        expect_result("neg_ovf", 16'h0000, 1'b1, 1'b1, 1'b0);
        expect_idle("neg_ovf");

        // Backpressure in DONE with new operands offered meanwhile.
        out_ready = 1'b0;
        accept_op(16'h1111, 16'h2222, 1'b0);
        expect_result("bp", 16'h3333, 1'b0, 1'b0, 1'b0);
        A        = 16'h0102;
        B        = 16'h0304;
        c_in     = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("bp_hold_out_valid", out_valid, 1'b1);
            chk1("bp_hold_in_ready", in_ready, 1'b0);
            chk16("bp_hold_S", S, 16'h3333);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk1("bp_release_in_ready", in_ready, 1'b1);
        chk1("bp_release_out_valid", out_valid, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk1("bp_second_accept", in_ready, 1'b0);
        expect_result("bp_next", 16'h0407, 1'b0, 1'b0, 1'b0);
        expect_idle("bp_next");

        // Reset in the second RUN cycle discards the operation.
        accept_op(16'hAAAA, 16'h5555, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk1("midrst_in_ready", in_ready, 1'b1);
        chk1("midrst_out_valid", out_valid, 1'b0);
        chk16("midrst_S", S, 16'h0000);
        chk1("midrst_c_out", c_out, 1'b0);
        chk1("midrst_ovf", ovf, 1'b0);
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        chk16("midrst_stray_out_valid", 16'(stray), 16'd0);
        accept_op(16'h0001, 16'h0001, 1'b0);
        expect_result("after_rst", 16'h0002, 1'b0, 1'b0, 1'b0);
        expect_idle("after_rst");

        // Inputs changing during RUN must not disturb the result.
        accept_op(16'h00FF, 16'h0001, 1'b0);
        expect_result("sampling", 16'h0100, 1'b0, 1'b0, 1'b1);
        expect_idle("sampling");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
